pipeline_mem: RTL and testbench

PIPELINE_MEM -- requirements
Module: pipeline_mem

---
 rtl/pipeline_mem_if.sv | 48 ++++
 rtl/pipeline_mem.sv | 166 ++++++++++++++++
 tb/tb_pipeline_mem.sv | 542 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_mem_if.sv
// pipeline_mem_if: EX-side, memory-side, writeback and fault signals
// of the MEM pipeline stage (master = environment, slave = stage).
interface pipeline_mem_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic                  in_valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] ex_res;
  logic [DATA_WIDTH-1:0] r2_val_mem;
  logic [4:0]            mem_dst_reg;
  logic [31:0]           next_mem_opcode;
  logic                  next_is_mem_load;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [1:0]            mem_size;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  wb_valid;
  logic                  wb_ready;
  logic [4:0]            wb_dst_reg;
  logic [DATA_WIDTH-1:0] wb_data;

  logic                  fault_valid;
  logic [ADDR_WIDTH-1:0] fault_addr;

  modport master (
    output in_valid, ex_res, r2_val_mem, mem_dst_reg,
    output next_mem_opcode, next_is_mem_load,
    output mem_ack, mem_rdata, wb_ready,
    input  ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_size, wb_valid, wb_dst_reg, wb_data,
    input  fault_valid, fault_addr
  );

  modport slave (
    input  in_valid, ex_res, r2_val_mem, mem_dst_reg,
    input  next_mem_opcode, next_is_mem_load,
    input  mem_ack, mem_rdata, wb_ready,
    output ready, mem_req, mem_we, mem_addr, mem_wdata,
    output mem_size, wb_valid, wb_dst_reg, wb_data,
    output fault_valid, fault_addr
  );
endinterface

// File: rtl/pipeline_mem.sv
// pipeline_mem: MEM stage (IDLE/REQ/WB) between EX and writeback.
// Define PIPELINE_MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module pipeline_mem #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input logic           clk,
  input logic           reset,
  pipeline_mem_if.slave bus
);
  typedef enum logic [1:0] { IDLE, REQ, WB } state_t;

  state_t                state;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [1:0]            mem_size_q;
  logic                  sext_q;
  logic [4:0]            dst_q;
  logic                  wb_valid_q;
  logic [4:0]            wb_dst_q;
  logic [DATA_WIDTH-1:0] wb_data_q;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [31:0]           op;
  logic                  acc_d;
  logic                  sext_d;
  logic [1:0]            size_d;
  logic                  mis;
  logic                  xfer;

  assign op = bus.next_mem_opcode;
  assign bus.ready = (state == IDLE) ||
                     (state == WB && bus.wb_ready);
  assign xfer = bus.in_valid && bus.ready;

  // Unknown access codes fall through to "no access".
  always_comb begin
    acc_d  = 1'b1;
    sext_d = 1'b0;
    size_d = 2'd0;
    unique case (1'b1)
      op == 32'd1: sext_d = 1'b1;
      op == 32'd2: begin size_d = 2'd1; sext_d = 1'b1; end
      op == 32'd3: begin size_d = 2'd2; sext_d = 1'b1; end
      op == 32'd4: size_d = 2'd3;
      op == 32'd5: size_d = 2'd0;
      op == 32'd6: size_d = 2'd1;
      op == 32'd7: size_d = 2'd2;
      default:     acc_d = 1'b0;
    endcase
  end

  always_comb begin
    ld_data = bus.mem_rdata;
    unique case (mem_size_q)
      2'd0: ld_data = {{(DATA_WIDTH-8){sext_q & bus.mem_rdata[7]}},
                       bus.mem_rdata[7:0]};
      2'd1: ld_data = {{(DATA_WIDTH-16){sext_q & bus.mem_rdata[15]}},
                       bus.mem_rdata[15:0]};
      2'd2: ld_data = {{(DATA_WIDTH-32){sext_q & bus.mem_rdata[31]}},
                       bus.mem_rdata[31:0]};
      default: ld_data = bus.mem_rdata;
    endcase
  end

`ifdef PIPELINE_MEM_MISALIGN_TRAP_EN
  logic                  fault_q;
  logic [ADDR_WIDTH-1:0] fault_addr_q;

  always_comb begin
    mis = 1'b0;
    unique case (size_d)
      2'd1:    mis = bus.ex_res[0];
      2'd2:    mis = |bus.ex_res[1:0];
      2'd3:    mis = |bus.ex_res[2:0];
      default: mis = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      fault_q <= xfer && acc_d && mis;
      if (xfer && acc_d && mis)
        fault_addr_q <= bus.ex_res[ADDR_WIDTH-1:0];
    end
  end

  assign bus.fault_valid = fault_q;
  assign bus.fault_addr  = fault_addr_q;
`else
  assign mis             = 1'b0;
  assign bus.fault_valid = 1'b0;
  assign bus.fault_addr  = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= 2'd0;
      sext_q      <= 1'b0;
      dst_q       <= 5'd0;
      wb_valid_q  <= 1'b0;
      wb_dst_q    <= 5'd0;
      wb_data_q   <= '0;
    end else begin
      unique case (state)
        REQ: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            state     <= IDLE;
            if (!mem_we_q && dst_q != 5'd0) begin
              wb_valid_q <= 1'b1;
              wb_dst_q   <= dst_q;
              wb_data_q  <= ld_data;
              state      <= WB;
            end
          end
        end
        IDLE, WB: begin
          if (state == WB && bus.wb_ready) begin
            wb_valid_q <= 1'b0;
            state      <= IDLE;
          end
          // A drained WB slot is refilled on the same edge.
          if (xfer) begin
            if (!acc_d) begin
              if (bus.mem_dst_reg != 5'd0) begin
                wb_valid_q <= 1'b1;
                wb_dst_q   <= bus.mem_dst_reg;
                wb_data_q  <= bus.ex_res;
                state      <= WB;
              end
            end else if (!mis) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= !bus.next_is_mem_load;
              mem_addr_q  <= bus.ex_res[ADDR_WIDTH-1:0];
              mem_wdata_q <= bus.r2_val_mem;
              mem_size_q  <= size_d;
              sext_q      <= sext_d;
              dst_q       <= bus.mem_dst_reg;
              state       <= REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_size   = mem_size_q;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_dst_reg = wb_dst_q;
  assign bus.wb_data    = wb_data_q;
endmodule

// File: tb/tb_pipeline_mem.sv
// tb_pipeline_mem: directed scenarios plus a randomized run checked
// against a transaction-level queue model of the MEM stage.
module tb_pipeline_mem;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipeline_mem_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

  pipeline_mem #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef PIPELINE_MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic [31:0] code;
    logic [4:0]  dst;
  } mreq_t;

  typedef struct {
    logic [4:0]  dst;
    logic [63:0] data;
  } wbe_t;

  mreq_t mq[$];
  wbe_t  wq[$];

  function automatic int size_of(logic [31:0] c);
    case (c)
      32'd1, 32'd5: return 0;
      32'd2, 32'd6: return 1;
      32'd3, 32'd7: return 2;
      32'd4:        return 3;
      default:      return -1;
    endcase
  endfunction

  function automatic logic [63:0] ext(logic [31:0] c, logic [63:0] rd);
    logic [63:0] b, h, w;
    b = 64'(rd[7:0]);
    h = 64'(rd[15:0]);
    w = 64'(rd[31:0]);
    case (c)
      32'd1:   return rd[7]  ? b - 64'd256 : b;
      32'd2:   return rd[15] ? h - 64'd65536 : h;
      32'd3:   return rd[31] ? w - 64'h1_0000_0000 : w;
      32'd5:   return b;
      32'd6:   return h;
      32'd7:   return w;
      default: return rd;
    endcase
  endfunction

  task automatic drive_idle();
    bus.in_valid         = 1'b0;
    bus.ex_res           = '0;
    bus.r2_val_mem       = '0;
    bus.mem_dst_reg      = 5'd0;
    bus.next_mem_opcode  = 32'd0;
    bus.next_is_mem_load = 1'b0;
    bus.mem_ack          = 1'b0;
    bus.mem_rdata        = '0;
    bus.wb_ready         = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic issue(logic [31:0] c, logic [63:0] a, logic [4:0] d,
                       logic ld, logic [63:0] r2);
    bus.in_valid         = 1'b1;
    bus.next_mem_opcode  = c;
    bus.ex_res           = a;
    bus.mem_dst_reg      = d;
    bus.next_is_mem_load = ld;
    bus.r2_val_mem       = r2;
  endtask

  task automatic test_reset();
    do_reset();
    issue(32'd0, 64'hCAFE, 5'd2, 1'b0, 64'h0);
    bus.wb_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    issue(32'd1, 64'h40, 5'd1, 1'b1, 64'h77);
    bus.wb_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.wb_valid, bus.fault_valid} !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_ctrl got=%b exp=0000",
               {bus.mem_req, bus.mem_we, bus.wb_valid, bus.fault_valid});
    end
    n_checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_size} !== '0) begin
      n_fail++;
      $display("FAIL rst_mem_data got=%h/%h/%h exp=0",
               bus.mem_addr, bus.mem_wdata, bus.mem_size);
    end
    n_checks++;
    if ({bus.wb_data, bus.wb_dst_reg, bus.fault_addr} !== '0) begin
      n_fail++;
      $display("FAIL rst_wb_data got=%h/%h/%h exp=0",
               bus.wb_data, bus.wb_dst_reg, bus.fault_addr);
    end
    n_checks++;
    if (bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready got=%b exp=1", bus.ready);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_no_req got=%b exp=0", bus.mem_req);
    end
  endtask

  task automatic test_alu_pass();
    do_reset();
    issue(32'd0, 64'h1234, 5'd5, 1'b0, 64'h0);
    #1;
    n_checks++;
    if (bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_ready got=%b exp=1", bus.ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if ({bus.wb_valid, bus.wb_dst_reg, bus.wb_data} !== {1'b1, 5'd5, 64'h1234}) begin
      n_fail++;
      $display("FAIL alu_wb got=%b/%0d/%h exp=1/5/1234",
               bus.wb_valid, bus.wb_dst_reg, bus.wb_data);
    end
    issue(32'd0, 64'h5555, 5'd0, 1'b0, 64'h0);
    @(negedge clk);
    issue(32'h0000_0009, 64'h9999, 5'd8, 1'b0, 64'h0);
    #1;
    n_checks++;
    if ({bus.wb_valid, bus.ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL alu_dst0 got=%b exp=01", {bus.wb_valid, bus.ready});
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if ({bus.wb_valid, bus.wb_dst_reg, bus.wb_data, bus.mem_req}
        !== {1'b1, 5'd8, 64'h9999, 1'b0}) begin
      n_fail++;
      $display("FAIL alu_badcode got=%b/%0d/%h/%b exp=1/8/9999/0",
               bus.wb_valid, bus.wb_dst_reg, bus.wb_data, bus.mem_req);
    end
  endtask

  task automatic test_signed_byte_load();
    int held;
    do_reset();
    issue(32'd1, 64'h100, 5'd3, 1'b1, 64'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    held = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'h80;
      end
      #1;
      if (bus.mem_req === 1'b1 && bus.mem_addr === 64'h100 &&
          bus.mem_size === 2'd0 && bus.mem_we === 1'b0)
        held++;
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    #1;
    n_checks++;
    if (held != 3) begin
      n_fail++;
      $display("FAIL ldb_req_held got=%0d exp=3", held);
    end
    n_checks++;
    if ({bus.mem_req, bus.wb_valid, bus.wb_dst_reg, bus.wb_data}
        !== {1'b0, 1'b1, 5'd3, 64'hFFFF_FFFF_FFFF_FF80}) begin
      n_fail++;
      $display("FAIL ldb_wb got=%b/%b/%0d/%h exp=0/1/3/ffffffffffffff80",
               bus.mem_req, bus.wb_valid, bus.wb_dst_reg, bus.wb_data);
    end
  endtask

  task automatic test_store();
    do_reset();
    issue(32'd4, 64'h200, 5'd7, 1'b0, 64'hDEAD);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_size, bus.ready}
        !== {1'b1, 1'b1, 64'h200, 64'hDEAD, 2'd3, 1'b0}) begin
      n_fail++;
      $display("FAIL st_req got=%b/%b/%h/%h/%0d/%b exp=1/1/200/dead/3/0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata,
               bus.mem_size, bus.ready);
    end
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_req, bus.wb_valid, bus.ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL st_done got=%b exp=001",
               {bus.mem_req, bus.wb_valid, bus.ready});
    end
    issue(32'd7, 64'h204, 5'd12, 1'b1, 64'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_size}
        !== {1'b1, 1'b0, 64'h204, 2'd2}) begin
      n_fail++;
      $display("FAIL st_next_req got=%b/%b/%h/%0d exp=1/0/204/2",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_size);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h1_8000_0000;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    n_checks++;
    if ({bus.wb_valid, bus.wb_dst_reg, bus.wb_data}
        !== {1'b1, 5'd12, 64'h8000_0000}) begin
      n_fail++;
      $display("FAIL lwu_wb got=%b/%0d/%h exp=1/12/80000000",
               bus.wb_valid, bus.wb_dst_reg, bus.wb_data);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    issue(32'd0, 64'hAAAA, 5'd9, 1'b0, 64'h0);
    bus.wb_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      n_checks++;
      if ({bus.ready, bus.wb_valid, bus.wb_dst_reg, bus.wb_data}
          !== {1'b0, 1'b1, 5'd9, 64'hAAAA}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d] got=%b/%b/%0d/%h exp=0/1/9/aaaa", k,
                 bus.ready, bus.wb_valid, bus.wb_dst_reg, bus.wb_data);
      end
    end
    @(negedge clk);
    bus.wb_ready = 1'b1;
    issue(32'd0, 64'hBBBB, 5'd10, 1'b0, 64'h0);
    #1;
    n_checks++;
    if (bus.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready got=%b exp=1", bus.ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if ({bus.wb_valid, bus.wb_dst_reg, bus.wb_data}
        !== {1'b1, 5'd10, 64'hBBBB}) begin
      n_fail++;
      $display("FAIL bp_next got=%b/%0d/%h exp=1/10/bbbb",
               bus.wb_valid, bus.wb_dst_reg, bus.wb_data);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.wb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain got=%b exp=0", bus.wb_valid);
    end
  endtask

  task automatic test_reset_mid_req();
    do_reset();
    issue(32'd3, 64'h300, 5'd4, 1'b1, 64'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rmr_req got=%b exp=1", bus.mem_req);
    end
    reset = 1'b1;
    issue(32'd0, 64'h11, 5'd1, 1'b0, 64'h0);
    bus.wb_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid  = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h1234_5678;
    #1;
    n_checks++;
    if ({bus.mem_req, bus.wb_valid, bus.ready, bus.mem_addr}
        !== {1'b0, 1'b0, 1'b1, 64'h0}) begin
      n_fail++;
      $display("FAIL rmr_after_rst got=%b/%b/%b/%h exp=0/0/1/0",
               bus.mem_req, bus.wb_valid, bus.ready, bus.mem_addr);
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    n_checks++;
    if ({bus.mem_req, bus.wb_valid, bus.ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL rmr_late_ack got=%b exp=001",
               {bus.mem_req, bus.wb_valid, bus.ready});
    end
  endtask

  task automatic test_misalign();
    do_reset();
    issue(32'd2, 64'h101, 5'd6, 1'b1, 64'h0);
    @(negedge clk);
    bus.in_valid = 1'b0;
`ifdef PIPELINE_MEM_MISALIGN_TRAP_EN
    #1;
    n_checks++;
    if ({bus.mem_req, bus.fault_valid, bus.fault_addr, bus.ready}
        !== {1'b0, 1'b1, 64'h101, 1'b1}) begin
      n_fail++;
      $display("FAIL mis_trap got=%b/%b/%h/%b exp=0/1/101/1",
               bus.mem_req, bus.fault_valid, bus.fault_addr, bus.ready);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({bus.mem_req, bus.fault_valid, bus.wb_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL mis_pulse got=%b exp=000",
               {bus.mem_req, bus.fault_valid, bus.wb_valid});
    end
`else
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'hFFFF_8001;
    #1;
    n_checks++;
    if ({bus.mem_req, bus.mem_addr, bus.mem_size, bus.fault_valid, bus.fault_addr}
        !== {1'b1, 64'h101, 2'd1, 1'b0, 64'h0}) begin
      n_fail++;
      $display("FAIL mis_issue got=%b/%h/%0d/%b/%h exp=1/101/1/0/0",
               bus.mem_req, bus.mem_addr, bus.mem_size,
               bus.fault_valid, bus.fault_addr);
    end
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    n_checks++;
    if ({bus.wb_valid, bus.wb_dst_reg, bus.wb_data}
        !== {1'b1, 5'd6, 64'hFFFF_FFFF_FFFF_8001}) begin
      n_fail++;
      $display("FAIL mis_wb got=%b/%0d/%h exp=1/6/ffffffffffff8001",
               bus.wb_valid, bus.wb_dst_reg, bus.wb_data);
    end
`endif
  endtask

  task automatic test_random();
    mreq_t       m;
    wbe_t        w;
    bit          fpend;
    bit          exp_rdy;
    logic [63:0] faddr;
    int          sz;
    int          r;
    fpend = 1'b0;
    faddr = '0;
    mq.delete();
    wq.delete();
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 149) == 0);
      bus.in_valid = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 11);
      bus.next_mem_opcode = (r < 9) ? 32'(r) : $urandom;
      bus.ex_res = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) bus.ex_res[2:0] = 3'd0;
      bus.r2_val_mem = {$urandom, $urandom};
      bus.mem_dst_reg = ($urandom_range(0, 5) == 0) ? 5'd0
                        : 5'($urandom_range(1, 31));
      bus.next_is_mem_load = 1'($urandom_range(0, 1));
      bus.wb_ready = ($urandom_range(0, 3) != 0);
      bus.mem_ack = ($urandom_range(0, 2) == 0);
      bus.mem_rdata = {$urandom, $urandom};
      #1;
      exp_rdy = (mq.size() == 0) && (wq.size() == 0 || bus.wb_ready);
      n_checks++;
      if (bus.ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, bus.ready, exp_rdy);
      end
      n_checks++;
      if (bus.mem_req !== (mq.size() != 0)) begin
        n_fail++;
        $display("FAIL rnd_mem_req cyc=%0d got=%b exp=%b",
                 cyc, bus.mem_req, mq.size() != 0);
      end
      if (mq.size() != 0) begin
        m = mq[0];
        n_checks++;
        if ({bus.mem_addr, bus.mem_we, bus.mem_size, bus.mem_wdata}
            !== {m.addr, m.we, m.size, m.wdata}) begin
          n_fail++;
          $display("FAIL rnd_mem_fields cyc=%0d got=%h/%b/%0d/%h exp=%h/%b/%0d/%h",
                   cyc, bus.mem_addr, bus.mem_we, bus.mem_size, bus.mem_wdata,
                   m.addr, m.we, m.size, m.wdata);
        end
      end
      n_checks++;
      if (bus.wb_valid !== (wq.size() != 0)) begin
        n_fail++;
        $display("FAIL rnd_wb_valid cyc=%0d got=%b exp=%b",
                 cyc, bus.wb_valid, wq.size() != 0);
      end
      if (wq.size() != 0) begin
        w = wq[0];
        n_checks++;
        if ({bus.wb_dst_reg, bus.wb_data} !== {w.dst, w.data}) begin
          n_fail++;
          $display("FAIL rnd_wb_fields cyc=%0d got=%0d/%h exp=%0d/%h",
                   cyc, bus.wb_dst_reg, bus.wb_data, w.dst, w.data);
        end
      end
`ifdef PIPELINE_MEM_MISALIGN_TRAP_EN
      n_checks++;
      if (bus.fault_valid !== fpend) begin
        n_fail++;
        $display("FAIL rnd_fault cyc=%0d got=%b exp=%b", cyc, bus.fault_valid, fpend);
      end
      if (fpend) begin
        n_checks++;
        if (bus.fault_addr !== faddr) begin
          n_fail++;
          $display("FAIL rnd_fault_addr cyc=%0d got=%h exp=%h",
                   cyc, bus.fault_addr, faddr);
        end
      end
`else
      n_checks++;
      if ({bus.fault_valid, bus.fault_addr} !== '0) begin
        n_fail++;
        $display("FAIL rnd_fault_tied cyc=%0d got=%b/%h exp=0/0",
                 cyc, bus.fault_valid, bus.fault_addr);
      end
`endif
      fpend = 1'b0;
      if (reset) begin
        mq.delete();
        wq.delete();
      end else begin
        if (mq.size() != 0 && bus.mem_ack) begin
          m = mq.pop_front();
          if (!m.we && m.dst != 5'd0) begin
            w.dst  = m.dst;
            w.data = ext(m.code, bus.mem_rdata);
            wq.push_back(w);
          end
        end else if (wq.size() != 0 && bus.wb_ready) begin
          w = wq.pop_front();
        end
        if (bus.in_valid && exp_rdy) begin
          sz = size_of(bus.next_mem_opcode);
          if (sz < 0) begin
            if (bus.mem_dst_reg != 5'd0) begin
              w.dst  = bus.mem_dst_reg;
              w.data = bus.ex_res;
              wq.push_back(w);
            end
          end else if (TRAP && (bus.ex_res % (64'd1 << sz)) != 64'd0) begin
            fpend = 1'b1;
            faddr = bus.ex_res;
          end else begin
            m.addr  = bus.ex_res;
            m.we    = !bus.next_is_mem_load;
            m.wdata = bus.r2_val_mem;
            m.size  = 2'(sz);
            m.code  = bus.next_mem_opcode;
            m.dst   = bus.mem_dst_reg;
            mq.push_back(m);
          end
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    test_reset();
    test_alu_pass();
    test_signed_byte_load();
    test_store();
    test_back_to_back();
    test_reset_mid_req();
    test_misalign();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
